// File: rtl/uart_tx_scheduler_if.sv
// Byte-request bundle between the requesters and the UART TX scheduler.
// The scheduler sits on the slave side of this interface.
interface uart_tx_scheduler_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;

    modport master (output req_valid, output req_data, input  req_ready);
    modport slave  (input  req_valid, input  req_data, output req_ready);
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin shared UART transmitter: grants one requester per 8N1 frame
// and serialises its byte using a 16x oversample baud tick.
module uart_tx_scheduler #(
    parameter  int N_REQ      = 4,
    parameter  int DATA_W     = 8,
    parameter  int OVERSAMPLE = 16,
    localparam int ID_W       = $clog2(N_REQ)
) (
    input  logic                Clk,
    input  logic                Resetn,
    input  logic                baud_tick,
    uart_tx_scheduler_if.slave  req_bus,
    output logic                tx,
    output logic                busy,
    output logic [ID_W-1:0]     grant_id,
    output logic                frame_done
);
    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t              state_reg, state_next;
    logic [TICK_W-1:0]   tick_cnt_reg;
    logic [BIT_W-1:0]    bit_cnt_reg;
    logic [DATA_W-1:0]   shift_reg;
    logic [ID_W-1:0]     rr_ptr_reg;
    logic [ID_W-1:0]     grant_id_reg;
    logic                frame_done_reg;

    logic [DATA_W-1:0]   req_byte [N_REQ];
    logic                pick_found;
    logic [ID_W-1:0]     pick_idx;
    logic [ID_W:0]       cand_sum;
    logic                ready_en;
    logic                handshake;
    logic                bit_end;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign req_byte[gi]          = req_bus.req_data[gi*DATA_W +: DATA_W];
            assign req_bus.req_ready[gi] = ready_en && (pick_idx == ID_W'(gi));
        end
    endgenerate

    // First valid requester at or after the pointer, wrapping modulo N_REQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_sum   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_sum = {1'b0, rr_ptr_reg} + (ID_W+1)'(k);
            if (cand_sum >= (ID_W+1)'(N_REQ)) begin
                cand_sum = cand_sum - (ID_W+1)'(N_REQ);
            end
            if (!pick_found && req_bus.req_valid[cand_sum[ID_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand_sum[ID_W-1:0];
            end
        end
    end

    assign handshake = (state_reg == S_IDLE) && pick_found;
    assign bit_end   = baud_tick && (tick_cnt_reg == TICK_W'(OVERSAMPLE - 1));

    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (handshake) state_next = S_START;
            S_START: if (bit_end)   state_next = S_DATA;
            S_DATA:  if (bit_end && (bit_cnt_reg == BIT_W'(DATA_W - 1))) state_next = S_STOP;
            S_STOP:  if (bit_end)   state_next = S_IDLE;
            default:                state_next = S_IDLE;
        endcase
    end

    always_comb begin
        tx       = 1'b1;
        busy     = (state_reg != S_IDLE);
        ready_en = 1'b0;
        case (state_reg)
            S_IDLE:  ready_en = pick_found;
            S_START: tx       = 1'b0;
            S_DATA:  tx       = shift_reg[0];
            default: tx       = 1'b1;
        endcase
    end

    // Ticks are only counted once a frame is underway; the handshake cycle clears the counters.
    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            tick_cnt_reg   <= '0;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            rr_ptr_reg     <= '0;
            grant_id_reg   <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= (state_reg == S_STOP) && bit_end;
            if (handshake) begin
                shift_reg    <= req_byte[pick_idx];
                grant_id_reg <= pick_idx;
                rr_ptr_reg   <= (pick_idx == ID_W'(N_REQ - 1)) ? '0 : pick_idx + ID_W'(1);
                tick_cnt_reg <= '0;
                bit_cnt_reg  <= '0;
            end else if ((state_reg != S_IDLE) && baud_tick) begin
                tick_cnt_reg <= bit_end ? '0 : tick_cnt_reg + TICK_W'(1);
                if ((state_reg == S_DATA) && bit_end) begin
                    shift_reg   <= shift_reg >> 1;
                    bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
                end
            end
        end
    end

    assign grant_id   = grant_id_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed scenarios plus random traffic, every
// cycle compared against a frame-level model (ticks elapsed since grant).
module tb_uart_tx_scheduler;
    localparam int N           = 4;
    localparam int DW          = 8;
    localparam int OS          = 16;
    localparam int FRAME_TICKS = OS * (DW + 2);

    logic         Clk       = 1'b0;
    logic         Resetn    = 1'b0;
    logic         baud_tick = 1'b0;
    logic         tx;
    logic         busy;
    logic [1:0]   grant_id;
    logic         frame_done;

    uart_tx_scheduler_if #(.N_REQ(N), .DATA_W(DW)) req_bus ();

    uart_tx_scheduler #(.N_REQ(N), .DATA_W(DW), .OVERSAMPLE(OS)) dut (
        .Clk        (Clk),
        .Resetn     (Resetn),
        .baud_tick  (baud_tick),
        .req_bus    (req_bus),
        .tx         (tx),
        .busy       (busy),
        .grant_id   (grant_id),
        .frame_done (frame_done)
    );

    always #5 Clk = ~Clk;

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Frame-level reference model state.
    bit         model_valid = 1'b0;
    bit         m_busy      = 1'b0;
    int         m_ticks     = 0;
    logic [7:0] m_data      = '0;
    int         m_ptr       = 0;
    int         m_grant     = 0;
    bit         m_done      = 1'b0;
    int         tick_phase  = 0;
    bit         tick_en     = 1'b1;
    int         dut_grants[$];

    function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic exp_tx_bit();
        int bi;
        if (!m_busy) return 1'b1;
        bi = m_ticks / OS;
        if (bi == 0) return 1'b0;
        if (bi <= DW) return m_data[bi-1];
        return 1'b1;
    endfunction

    task automatic cycle();
        int         g;
        logic [N-1:0] exp_ready;
        @(negedge Clk);
        g = m_busy ? -1 : rr_pick(req_bus.req_valid, m_ptr);
        exp_ready = (g >= 0) ? (N'(1) << g) : '0;
        if (model_valid) begin
            check_eq("req_ready", 32'(req_bus.req_ready), 32'(exp_ready));
            check_eq("tx", 32'(tx), 32'(exp_tx_bit()));
            check_eq("busy", 32'(busy), 32'(m_busy));
            check_eq("grant_id", 32'(grant_id), m_grant);
            check_eq("frame_done", 32'(frame_done), 32'(m_done));
        end
        if (!Resetn) begin
            model_valid = 1'b1;
            m_busy = 1'b0; m_ticks = 0; m_ptr = 0; m_grant = 0; m_done = 1'b0;
        end else if (!m_busy) begin
            m_done = 1'b0;
            if (g >= 0) begin
                m_busy  = 1'b1;
                m_ticks = 0;
                m_data  = req_bus.req_data[g*DW +: DW];
                m_grant = g;
                m_ptr   = (g + 1) % N;
                dut_grants.push_back(onehot_idx(req_bus.req_ready));
                $display("handshake req=%0d data=%02h t=%0t", g, m_data, $time);
            end
        end else begin
            m_done = 1'b0;
            if (baud_tick) begin
                m_ticks++;
                if (m_ticks == FRAME_TICKS) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    $display("frame done req=%0d data=%02h t=%0t", m_grant, m_data, $time);
                end
            end
        end
        @(posedge Clk);
        #1;
        tick_phase = (tick_phase + 1) % 4;
        baud_tick  = tick_en && (tick_phase == 3);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic wait_done(input int maxc);
        int c = 0;
        do begin
            cycle();
            c++;
        end while (!m_done && c < maxc);
        check_eq("frame_timeout", 32'(c < maxc), 32'd1);
        cycle();
    endtask

    task automatic do_reset();
        Resetn = 1'b0;
        run(2);
        Resetn = 1'b1;
    endtask

    task automatic check_grants(input string tag, input int base, input int exp0, input int exp1, input int exp2);
        int e[3];
        e = '{exp0, exp1, exp2};
        for (int i = 0; i < 3; i++) begin
            check_eq(tag, (base + i < dut_grants.size()) ? dut_grants[base + i] : 32'hdead, e[i]);
        end
    endtask

    initial begin
        int base;
        req_bus.req_valid = '0;
        req_bus.req_data  = '0;

        // 1: single byte from requester 0
        do_reset();
        req_bus.req_valid = 4'b0001;
        req_bus.req_data  = {8'h00, 8'h00, 8'h00, 8'hA5};
        cycle();
        req_bus.req_valid = '0;
        wait_done(1000);
        run(3);
        check_eq("s1_grant", (dut_grants.size() > 0) ? dut_grants[dut_grants.size()-1] : 32'hdead, 0);

        // 2: all valid, round-robin order 0,1,2,3,0
        do_reset();
        base = dut_grants.size();
        req_bus.req_valid = 4'b1111;
        req_bus.req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        repeat (5) wait_done(1000);
        req_bus.req_valid = '0;
        run(2);
        check_grants("s2_order", base, 0, 1, 2);
        check_grants("s2_order_tail", base + 2, 2, 3, 0);

        // 3: after a frame from 2, 0101 wraps to 0 then 2
        base = dut_grants.size();
        req_bus.req_valid = 4'b0100;
        cycle();
        req_bus.req_valid = 4'b0101;
        repeat (3) wait_done(1000);
        req_bus.req_valid = '0;
        run(2);
        check_grants("s3_wrap", base, 2, 0, 2);

        // 4: reset during data bit 3 aborts the frame
        req_bus.req_valid = 4'b0100;
        req_bus.req_data  = {8'h00, 8'h3C, 8'h00, 8'h00};
        cycle();
        req_bus.req_valid = '0;
        while (m_ticks < 4*OS + 5) cycle();
        Resetn = 1'b0;
        cycle();
        Resetn = 1'b1;
        check_eq("s4_tx_after_rst", 32'(tx), 32'd1);
        check_eq("s4_busy_after_rst", 32'(busy), 32'd0);
        run(5);
        base = dut_grants.size();
        req_bus.req_valid = 4'b1111;
        cycle();
        req_bus.req_valid = '0;
        check_eq("s4_next_grant", (base < dut_grants.size()) ? dut_grants[base] : 32'hdead, 0);
        wait_done(1000);

        // 5: ticks stalled inside the start bit
        req_bus.req_valid = 4'b0010;
        req_bus.req_data  = {8'h00, 8'h00, 8'h5A, 8'h00};
        cycle();
        req_bus.req_valid = '0;
        while (m_ticks < 3) cycle();
        tick_en = 1'b0;
        run(500);
        check_eq("s5_tx_held", 32'(tx), 32'd0);
        check_eq("s5_busy_held", 32'(busy), 32'd1);
        tick_en = 1'b1;
        wait_done(1000);

        // 6: valid drops and data changes after the handshake
        req_bus.req_valid = 4'b1000;
        req_bus.req_data  = {8'h96, 8'h00, 8'h00, 8'h00};
        cycle();
        req_bus.req_valid = '0;
        req_bus.req_data  = {8'h69, 8'hFF, 8'hFF, 8'hFF};
        wait_done(1000);

        // Random traffic with occasional resets and tick stalls
        for (int it = 0; it < 30; it++) begin
            req_bus.req_valid = 4'($urandom_range(0, 15));
            req_bus.req_data  = $urandom();
            tick_en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 9) == 0) begin
                Resetn = 1'b0;
                cycle();
                Resetn = 1'b1;
            end
            run($urandom_range(1, 700));
        end
        tick_en = 1'b1;
        req_bus.req_valid = '0;
        run(700);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
